mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, giving the maximum cycles to wait for bus_ack per byte before aborting.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; reset is synchronous and active-high.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: access request, sampled only when ready=1.
REQ-005 The block SHALL have port mem_read, input, 3 bits: 110 lw, 100 lb, 010 lh, 111 lui, 000 none.
REQ-006 The block SHALL have port mem_write, input, 2 bits: 11 sw, 10 sh, 01 sb, 00 none.
REQ-007 The block SHALL have ports addr (input, 32 bits: byte address) and wdata (input, 32 bits: store data, or lui immediate in bits [15:0]).
REQ-008 The block SHALL have ports ready (output, 1 bit: idle and accepting) and done (output, 1-cycle completion pulse).
REQ-009 The block SHALL have ports rdata (output, 32 bits: load/lui result) and err (output, 1 bit: valid with done).
REQ-010 The block SHALL have ports bus_req, bus_we, bus_addr[31:0] and bus_wdata[7:0] as outputs, and bus_ack and bus_rdata[7:0] as inputs, forming a byte-wide memory bus.

Function
REQ-011 ready SHALL be 1 only in IDLE; a start while ready=0 SHALL be ignored.
REQ-012 On an accepted start, the block SHALL latch mem_read, mem_write, addr and wdata, and derive byte count N (1 for b, 2 for h, 4 for w).
REQ-013 The FSM SHALL have four states: IDLE, BUS, DONE and ABORT.
REQ-014 The block SHALL go from IDLE to DONE with err=1, and no bus traffic, in any of these cases:
  - misaligned access (half with addr[0]=1; word with addr[1:0]!=0);
  - mem_read and mem_write both nonzero;
  - unlisted mem_read code.
REQ-015 mem_read=000 with mem_write=00 SHALL go IDLE to DONE with err=0 and rdata unchanged.
REQ-016 lui SHALL go IDLE to DONE with rdata={wdata[15:0],16'h0000}, err=0, and no bus traffic.
REQ-017 Otherwise the FSM SHALL go IDLE to BUS with byte index k=0.
REQ-018 In BUS, bus_req SHALL be 1, bus_addr SHALL be addr+k, and bus_we SHALL be 1 for stores.
REQ-019 Store byte order SHALL be big-endian: byte k = bits [8(N-1-k)+7 : 8(N-1-k)] of wdata.
REQ-020 Each cycle with bus_req=1 and bus_ack=1 SHALL complete byte k; loads capture bus_rdata big-endian.
REQ-021 After each completed byte, k SHALL increment; on k=N-1 the FSM SHALL move to DONE, and bus_req SHALL be 0 in DONE.
REQ-022 The per-byte timeout counter SHALL clear on each ack; if it reaches TIMEOUT the FSM SHALL go to ABORT, then to DONE with err=1.
REQ-023 Loads SHALL sign-extend: lb from bit 7, lh from bit 15; lw SHALL be unmodified.
REQ-024 In DONE, done SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE; rdata and err SHALL hold until the next accepted start.
REQ-025 Latency with immediate acks SHALL be: start accepted at edge T, first bus_req at T+1, done at T+1+N.
REQ-026 A bus_ack while bus_req=0 SHALL be ignored.

Reset
REQ-027 When reset=1 at a clk edge, the state SHALL become IDLE with ready=1, done=0, err=0, rdata=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, k=0 and the timeout counter=0.
REQ-028 Reset during BUS SHALL drop bus_req at that edge, produce no done pulse, and discard any partial load data.

Structure
REQ-029 A shared package mem_access_pkg SHALL hold the mem_read/mem_write encodings, the FSM state enum, and the byte-count function.
REQ-030 Load sign/zero extension SHALL be one combinational sub-module, load_extend.

Verification
REQ-031 Scenario: lw, addr=0x100, bus_rdata 0x12,0x34,0x56,0x78 with immediate acks -> bus_addr 0x100..0x103, done at T+5, rdata=0x12345678, err=0.
REQ-032 Scenario: lb, addr=0x7, bus_rdata=0x80 -> rdata=0xFFFFFF80; lh, addr=0x6, bytes 0x7F,0xFF -> rdata=0x00007FFF.
REQ-033 Scenario: sh, addr=0x22, wdata=0xAAAABEEF -> bus_we=1, bytes 0xBE@0x22 and 0xEF@0x23; sw, addr=0x21 -> done, err=1, no bus_req.
REQ-034 Scenario: sb with bus_ack held low and TIMEOUT=4 -> bus_req low after 4 cycles, done with err=1.
REQ-035 Scenario: lui, wdata=0x00001234 -> rdata=0x12340000 at T+1; a second start while busy is ignored.
REQ-036 Scenario: reset asserted after 2 of 4 lw bytes -> bus_req=0 at that edge, no done, ready=1.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared encodings, FSM state type and byte-count helper for the memory access unit.
package mem_access_pkg;

  localparam logic [2:0] RD_NONE = 3'b000;
  localparam logic [2:0] RD_LB   = 3'b100;
  localparam logic [2:0] RD_LH   = 3'b010;
  localparam logic [2:0] RD_LW   = 3'b110;
  localparam logic [2:0] RD_LUI  = 3'b111;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_SB   = 2'b01;
  localparam logic [1:0] WR_SH   = 2'b10;
  localparam logic [1:0] WR_SW   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  // Bytes moved on the bus for an access; 0 for lui / none / unlisted codes.
  function automatic logic [2:0] byte_count(input logic [2:0] rd, input logic [1:0] wr);
    logic [2:0] n;
    case (rd)
      RD_LB:   n = 3'd1;
      RD_LH:   n = 3'd2;
      RD_LW:   n = 3'd4;
      default: begin
        case (wr)
          WR_SB:   n = 3'd1;
          WR_SH:   n = 3'd2;
          WR_SW:   n = 3'd4;
          default: n = 3'd0;
        endcase
      end
    endcase
    return n;
  endfunction

  function automatic logic rd_code_valid(input logic [2:0] rd);
    return (rd == RD_NONE) || (rd == RD_LB) || (rd == RD_LH) ||
           (rd == RD_LW) || (rd == RD_LUI);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Byte-wide memory bus. A byte transfers on every cycle where bus_req and
// bus_ack are both high; bus_req holds addr/we/wdata stable until acked, and
// bus_ack is meaningless while bus_req is low.
interface mem_access_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack;
  logic [7:0]  bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Sign extension of assembled load data: lb from bit 7, lh from bit 15, lw as-is.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [2:0]  mem_read_i,
  input  logic [31:0] raw_i,
  output logic [31:0] ext_o
);

  // Pick the extension by load width.
  always_comb begin
    ext_o = raw_i;
    case (mem_read_i)
      RD_LB:   ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
      RD_LH:   ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
      default: ext_o = raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit that splits b/h/w accesses into big-endian byte transfers
// on a byte-wide bus, with per-byte ack timeout and early error rejection.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mem_read,
  input  logic [1:0]  mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  mem_access_if.master bus,
  output state_t      dbg_state
);

  // Counter only needs to reach TIMEOUT-1: the cycle after that is the abort.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [2:0]    rd_q, rd_d;
  logic [1:0]    wr_q, wr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [1:0]    k_q, k_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [23:0]   acc_q, acc_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [2:0]    n_cur;
  logic [2:0]    n_new;
  logic [1:0]    bidx;
  logic          last_byte;
  logic          bad_req;
  logic          in_bus;
  logic [31:0]   ext_val;

  assign n_cur     = byte_count(rd_q, wr_q);
  assign last_byte = (k_q == 2'(n_cur - 3'd1));
  // Big-endian: byte k of the store comes from lane N-1-k.
  assign bidx      = 2'(n_cur - 3'd1) - k_q;
  assign n_new     = byte_count(mem_read, mem_write);
  assign bad_req   = !rd_code_valid(mem_read) ||
                     ((mem_read != RD_NONE) && (mem_write != WR_NONE)) ||
                     ((n_new == 3'd2) && addr[0]) ||
                     ((n_new == 3'd4) && (addr[1:0] != 2'b00));

  // The final byte is folded in combinationally so rdata lands with DONE.
  load_extend u_load_extend (
    .mem_read_i (rd_q),
    .raw_i      ({acc_q, bus.bus_rdata}),
    .ext_o      (ext_val)
  );

  assign in_bus         = (state_q == ST_BUS);
  assign ready          = (state_q == ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign rdata          = rdata_q;
  assign err            = err_q;
  assign dbg_state      = state_q;
  assign bus.bus_req    = in_bus;
  assign bus.bus_we     = in_bus && (wr_q != WR_NONE);
  assign bus.bus_addr   = in_bus ? (addr_q + {30'd0, k_q}) : 32'd0;
  assign bus.bus_wdata  = (in_bus && (wr_q != WR_NONE)) ? wdata_q[{bidx, 3'b000} +: 8] : 8'd0;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rd_q    <= RD_NONE;
      wr_q    <= WR_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
      k_q     <= '0;
      tmo_q   <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      k_q     <= k_d;
      tmo_q   <= tmo_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state: decode on start, walk bytes in BUS, abort on ack timeout.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    k_d     = k_q;
    tmo_d   = tmo_q;
    acc_d   = acc_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rd_d    = mem_read;
          wr_d    = mem_write;
          addr_d  = addr;
          wdata_d = wdata;
          k_d     = '0;
          tmo_d   = '0;
          acc_d   = '0;
          if (bad_req) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else if ((mem_read == RD_NONE) && (mem_write == WR_NONE)) begin
            err_d   = 1'b0;
            state_d = ST_DONE;
          end else if (mem_read == RD_LUI) begin
            rdata_d = {wdata[15:0], 16'h0000};
            err_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (bus.bus_ack) begin
          acc_d = {acc_q[15:0], bus.bus_rdata};
          tmo_d = '0;
          if (last_byte) begin
            state_d = ST_DONE;
            if (rd_q != RD_NONE) rdata_d = ext_val;
          end else begin
            k_d = k_q + 2'd1;
          end
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = ST_ABORT;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_ABORT: begin
        err_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        k_d     = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized accesses,
// checked against a byte-array memory model and a bus transaction queue.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mem_read;
  logic [1:0]  mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic [31:0] rdata;
  logic        err;
  state_t      dbg_state;

  mem_access_if bus_if ();

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  mem [0:1023];
  logic [40:0] exp_q[$];          // {we, addr[31:0], store byte}
  logic [40:0] txn_e;
  int          ack_dly_max = 0;
  bit          ack_block   = 1'b0;
  int          wait_cnt    = 0;
  int          cur_dly     = 0;

  logic [31:0] model_rdata = 32'd0;
  bit          rdata_known = 1'b1;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Memory responder and bus scoreboard; drives on negedge, DUT samples on posedge.
  always @(negedge clk) begin
    if (bus_if.bus_req && !ack_block) begin
      if (wait_cnt >= cur_dly) begin
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = mem[bus_if.bus_addr[9:0]];
        wait_cnt = 0;
        cur_dly  = $urandom_range(0, ack_dly_max);
        n_checks++;
        assert (exp_q.size() != 0) n_pass++;
        else $error("FAIL bus_unexpected: observed we=%0b addr=%h, expected no transfer",
                    bus_if.bus_we, bus_if.bus_addr);
        if (exp_q.size() != 0) begin
          txn_e = exp_q.pop_front();
          check32("bus_we", {31'd0, bus_if.bus_we}, {31'd0, txn_e[40]});
          check32("bus_addr", bus_if.bus_addr, txn_e[39:8]);
          if (txn_e[40]) check32("bus_wdata", {24'd0, bus_if.bus_wdata}, {24'd0, txn_e[7:0]});
        end
      end else begin
        bus_if.bus_ack   = 1'b0;
        bus_if.bus_rdata = 8'($urandom);
        wait_cnt++;
      end
    end else if (bus_if.bus_req) begin
      bus_if.bus_ack   = 1'b0;
      bus_if.bus_rdata = 8'($urandom);
    end else begin
      // stray acks while idle must be ignored by the DUT
      bus_if.bus_ack   = 1'($urandom_range(0, 1));
      bus_if.bus_rdata = 8'($urandom);
      wait_cnt = 0;
      cur_dly  = $urandom_range(0, ack_dly_max);
    end
  end

  // driver + reference model for one access
  task automatic do_access(input logic [2:0] rd, input logic [1:0] wr, input logic [31:0] a,
                           input logic [31:0] wd, input int dly, input bit block, input bit poke);
    int          n;
    bit          exp_err, is_bus, is_load, seen, chk_rd;
    logic [31:0] exp_rd, sh;
    logic [9:0]  idx;
    int          lat, reqcnt;
    n = 0;
    if (rd == 3'b110 || wr == 2'b11) n = 4;
    else if (rd == 3'b010 || wr == 2'b10) n = 2;
    else if (rd == 3'b100 || wr == 2'b01) n = 1;
    exp_err = !(rd inside {3'b000, 3'b100, 3'b010, 3'b110, 3'b111}) ||
              (rd != 3'b000 && wr != 2'b00) ||
              (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    is_bus  = !exp_err && (n > 0);
    is_load = is_bus && (rd != 3'b000);
    if (block && is_bus) exp_err = 1'b1;
    exp_rd = model_rdata;
    chk_rd = 1'b0;
    if (!exp_err && rd == 3'b111) begin
      exp_rd = {wd[15:0], 16'h0000};
      chk_rd = 1'b1;
    end
    if (is_load && !block) begin
      exp_rd = 32'd0;
      for (int i = 0; i < n; i++) begin
        idx = a[9:0] + 10'(i);
        exp_rd = (exp_rd << 8) | {24'd0, mem[idx]};
      end
      if (n == 1 && exp_rd[7])  exp_rd = exp_rd | 32'hFFFF_FF00;
      if (n == 2 && exp_rd[15]) exp_rd = exp_rd | 32'hFFFF_0000;
      chk_rd = 1'b1;
    end
    if (rd == 3'b000 && wr == 2'b00 && rdata_known) chk_rd = 1'b1;
    if (is_bus && !block) begin
      for (int i = 0; i < n; i++) begin
        sh = wd >> (8 * (n - 1 - i));
        exp_q.push_back({(wr != 2'b00), a + 32'(i), sh[7:0]});
      end
    end

    ack_dly_max = dly;
    ack_block   = block;
    @(negedge clk);
    @(negedge clk);
    check32("ready_before_start", {31'd0, ready}, 32'd1);
    start = 1'b1; mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    start = 1'b0;
    mem_read = 3'($urandom); mem_write = 2'($urandom); addr = $urandom; wdata = $urandom;

    seen = 1'b0; lat = 0; reqcnt = 0;
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      @(negedge clk);
      if (bus_if.bus_req) reqcnt++;
      if (poke && cyc == 1) begin
        check32("ready_while_busy", {31'd0, ready}, 32'd0);
        start = 1'b1;
      end else if (cyc == 2) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        lat  = cyc;
      end
    end
    check32("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      check32("err", {31'd0, err}, {31'd0, exp_err});
      if (chk_rd) check32("rdata", rdata, exp_rd);
      if (!is_bus)          check32("latency", lat, 1);
      else if (block)       check32("latency", lat, TMO + 2);
      else if (dly == 0)    check32("latency", lat, n + 1);
      if (!is_bus)          check32("bus_req_cycles", reqcnt, 0);
      else if (block)       check32("bus_req_cycles", reqcnt, TMO);
      else if (dly == 0)    check32("bus_req_cycles", reqcnt, n);
    end
    @(negedge clk);
    start = 1'b0;
    check32("done_one_cycle", {31'd0, done}, 32'd0);
    check32("ready_after_done", {31'd0, ready}, 32'd1);
    @(negedge clk);
    check32("no_extra_done", {31'd0, done}, 32'd0);
    check32("bus_q_drained", exp_q.size(), 32'd0);

    if (is_bus && !block && wr != 2'b00) begin
      for (int i = 0; i < n; i++) begin
        sh  = wd >> (8 * (n - 1 - i));
        idx = a[9:0] + 10'(i);
        mem[idx] = sh[7:0];
      end
    end
    if (exp_err || (is_bus && wr != 2'b00)) rdata_known = 1'b0;
    else if (chk_rd) begin
      model_rdata = exp_rd;
      rdata_known = 1'b1;
    end
    ack_block = 1'b0;
  endtask

  initial begin
    logic [2:0]  r_rd;
    logic [1:0]  r_wr;
    logic [31:0] r_a;
    int          sel;

    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    reset = 1'b1; start = 1'b0; mem_read = 3'd0; mem_write = 2'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check32("rst_ready", {31'd0, ready}, 32'd1);
    check32("rst_done", {31'd0, done}, 32'd0);
    check32("rst_err", {31'd0, err}, 32'd0);
    check32("rst_rdata", rdata, 32'd0);
    check32("rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
    check32("rst_bus_we", {31'd0, bus_if.bus_we}, 32'd0);
    check32("rst_bus_addr", bus_if.bus_addr, 32'd0);
    check32("rst_bus_wdata", {24'd0, bus_if.bus_wdata}, 32'd0);
    check32("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // lw with immediate acks
    mem[10'h100] = 8'h12; mem[10'h101] = 8'h34; mem[10'h102] = 8'h56; mem[10'h103] = 8'h78;
    do_access(3'b110, 2'b00, 32'h100, 32'h0, 0, 1'b0, 1'b0);
    check32("lw_value", rdata, 32'h1234_5678);
    // lb / lh sign extension
    mem[10'h007] = 8'h80;
    do_access(3'b100, 2'b00, 32'h7, 32'h0, 0, 1'b0, 1'b0);
    check32("lb_value", rdata, 32'hFFFF_FF80);
    mem[10'h006] = 8'h7F; mem[10'h007] = 8'hFF;
    do_access(3'b010, 2'b00, 32'h6, 32'h0, 0, 1'b0, 1'b0);
    check32("lh_value", rdata, 32'h0000_7FFF);
    // lui with an ignored start while busy, then a none access holding rdata
    do_access(3'b111, 2'b00, 32'h0, 32'h0000_1234, 0, 1'b0, 1'b1);
    check32("lui_value", rdata, 32'h1234_0000);
    do_access(3'b000, 2'b00, 32'h55, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    check32("none_holds_rdata", rdata, 32'h1234_0000);
    // stores, misaligned word, timeout
    do_access(3'b000, 2'b10, 32'h22, 32'hAAAA_BEEF, 0, 1'b0, 1'b1);
    do_access(3'b000, 2'b11, 32'h21, 32'h1111_2222, 0, 1'b0, 1'b0);
    do_access(3'b000, 2'b01, 32'h40, 32'h0000_00A5, 0, 1'b1, 1'b0);
    check32("bus_idle_after_abort", {31'd0, bus_if.bus_req}, 32'd0);
    // other rejected requests
    do_access(3'b110, 2'b11, 32'h80, 32'h0, 0, 1'b0, 1'b0);
    do_access(3'b001, 2'b00, 32'h80, 32'h0, 0, 1'b0, 1'b0);
    do_access(3'b010, 2'b00, 32'h81, 32'h0, 0, 1'b0, 1'b0);
    // readback of the earlier sh
    do_access(3'b010, 2'b00, 32'h22, 32'h0, 1, 1'b0, 1'b0);
    check32("sh_readback", rdata, 32'hFFFF_BEEF);

    // randomized accesses
    for (int t = 0; t < 40; t++) begin
      sel  = $urandom_range(0, 9);
      r_rd = 3'b000; r_wr = 2'b00;
      case (sel)
        0, 1: r_rd = 3'b110;
        2:    r_rd = 3'b100;
        3:    r_rd = 3'b010;
        4:    r_wr = 2'b11;
        5:    r_wr = 2'b10;
        6:    r_wr = 2'b01;
        7:    r_rd = 3'b111;
        8:    ;
        default: begin r_rd = 3'($urandom); r_wr = 2'($urandom); end
      endcase
      r_a = 32'($urandom_range(0, 1019));
      if ($urandom_range(0, 3) != 0) r_a[1:0] = 2'b00;
      do_access(r_rd, r_wr, r_a, $urandom, $urandom_range(0, 2), 1'b0, ($urandom_range(0, 3) == 0));
    end

    // reset in the middle of a word load
    ack_dly_max = 0;
    exp_q.push_back({1'b0, 32'h200, 8'h00});
    exp_q.push_back({1'b0, 32'h201, 8'h00});
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; mem_read = 3'b110; mem_write = 2'b00; addr = 32'h200; wdata = 32'h0;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    ack_block = 1'b1;
    @(negedge clk);
    check32("bus_req_before_reset", {31'd0, bus_if.bus_req}, 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check32("mid_rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
    check32("mid_rst_ready", {31'd0, ready}, 32'd1);
    check32("mid_rst_done", {31'd0, done}, 32'd0);
    check32("mid_rst_rdata", rdata, 32'd0);
    check32("mid_rst_err", {31'd0, err}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check32("no_done_after_reset", {31'd0, done}, 32'd0);
    end
    check32("rst_bus_q_drained", exp_q.size(), 32'd0);
    ack_block   = 1'b0;
    model_rdata = 32'd0;
    rdata_known = 1'b1;

    // recovery after reset
    do_access(3'b110, 2'b00, 32'h200, 32'h0, 0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
